hack_boot_sequencer: RTL and testbench



---
 rtl/hack_seq_pkg.sv | 24 ++
 rtl/hack_loop_detect.sv | 66 ++++++
 rtl/hack_boot_sequencer.sv | 144 ++++++++++++++
 tb/tb_hack_boot_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_seq_pkg.sv
// Purpose: shared types and constants for the Hack boot sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hack_seq_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_BOOT,
        S_PAUSE,
        S_RUN,
        S_STEP,
        S_DONE
    } state_t;

    // "(END) @END; 0;JMP" occupies two consecutive ROM words.
    localparam logic [15:0] LOOP_STEP = 16'd1;

endpackage

// File: rtl/hack_loop_detect.sv
// Purpose: detects the Hack end-of-program tight loop from the CPU's pc stream.
// Latency: hit is combinational on the enabled cycle that completes HALT_CNT iterations.
// Backpressure: none; samples pc only on cycles where en is high.
//
// Ports: clk/reset (sync, active-high), clear (wipe history and count),
//        en (CPU executed this cycle), pc (CPU program counter), hit (halt found).
module hack_loop_detect
    import hack_seq_pkg::*;
#(
    parameter int ROM_AW   = 15,
    parameter int HALT_CNT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        en,
    input  logic [15:0] pc,
    output logic        hit
);

    localparam int CNT_W = $clog2(HALT_CNT + 1);
    localparam logic [ROM_AW-1:0] STEP = LOOP_STEP[ROM_AW-1:0];

    logic [ROM_AW-1:0] pc_cur;
    logic [ROM_AW-1:0] pc_d1;
    logic [ROM_AW-1:0] pc_d2;
    logic [1:0]        hist_vld;
    logic [CNT_W-1:0]  match_cnt;
    logic              alt;
    logic              at_top;
    logic              at_jmp;
    logic              unused_pc;

    assign pc_cur    = pc[ROM_AW-1:0];
    assign unused_pc = ^(pc >> ROM_AW);

    // The loop alternates between END and END+1. Landing back on END
    // (coming from END+1) counts one iteration; the JMP half of the loop
    // keeps the count, anything else breaks the pattern and clears it.
    always_comb begin
        alt    = hist_vld[1] && (pc_cur == pc_d2);
        at_top = alt && (pc_d1 == pc_cur + STEP);
        at_jmp = alt && (pc_cur == pc_d1 + STEP);
        hit    = en && at_top && (match_cnt == CNT_W'(HALT_CNT - 1));
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pc_d1     <= '0;
            pc_d2     <= '0;
            hist_vld  <= '0;
            match_cnt <= '0;
        end else if (en) begin
            pc_d1    <= pc_cur;
            pc_d2    <= pc_d1;
            hist_vld <= {hist_vld[0], 1'b1};
            if (at_top) begin
                if (match_cnt != CNT_W'(HALT_CNT))
                    match_cnt <= match_cnt + CNT_W'(1);
            end else if (!at_jmp) begin
                match_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/hack_boot_sequencer.sv
// Purpose: owns the Hack CPU lifecycle: byte-stream ROM load, boot reset, run/step/pause, halt parking.
// Latency: ROM write is registered one cycle after the low data byte handshake.
// Backpressure: load_ready high only in the load states; load_valid low simply stalls.
//
// Ports: clk/reset (sync, active-high); load_start/load_valid/load_data/load_ready (loader);
//        cmd_run/cmd_step/cmd_pause (execution control); pc (CPU program counter);
//        rom_we/rom_addr/rom_wdata (ROM write port); cpu_reset, cpu_en, halted, busy_load (status).
module hack_boot_sequencer
    import hack_seq_pkg::*;
#(
    parameter int ROM_AW      = 15,
    parameter int BOOT_CYCLES = 4,
    parameter int HALT_CNT    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    output logic              load_ready,
    input  logic              cmd_run,
    input  logic              cmd_step,
    input  logic              cmd_pause,
    input  logic [15:0]       pc,
    output logic              rom_we,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [15:0]       rom_wdata,
    output logic              cpu_reset,
    output logic              cpu_en,
    output logic              halted,
    output logic              busy_load
);

    localparam int BOOT_W = $clog2(BOOT_CYCLES + 1);

    state_t            state;
    state_t            state_n;
    logic [7:0]        len_hi;
    logic [7:0]        hi_byte;
    logic [15:0]       nwords;
    logic [15:0]       widx;
    logic [BOOT_W-1:0] boot_cnt;
    logic              hs;
    logic              in_range;
    logic              det_clear;
    logic              det_hit;

    assign hs       = load_valid && load_ready;
    // Words past the end of the ROM are consumed but never written (no wrap).
    assign in_range = ((widx >> ROM_AW) == 16'd0);

    // Status outputs are pure state decodes.
    always_comb begin
        busy_load  = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                     (state == S_DATA_HI) || (state == S_DATA_LO);
        load_ready = busy_load;
        cpu_en     = (state == S_RUN) || (state == S_STEP);
        cpu_reset  = !((state == S_PAUSE) || (state == S_RUN) ||
                       (state == S_STEP) || (state == S_DONE));
        halted     = (state == S_DONE);
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (load_start) state_n = S_LEN_HI;
            S_LEN_HI:  if (hs) state_n = S_LEN_LO;
            S_LEN_LO:  if (hs) state_n = ({len_hi, load_data} == 16'd0) ? S_BOOT : S_DATA_HI;
            S_DATA_HI: if (hs) state_n = S_DATA_LO;
            S_DATA_LO: if (hs) state_n = (widx == nwords - 16'd1) ? S_BOOT : S_DATA_HI;
            S_BOOT:    if (boot_cnt == BOOT_W'(BOOT_CYCLES - 1)) state_n = S_PAUSE;
            S_PAUSE: begin
                // A new load outranks any execution command; run outranks step.
                if (load_start)    state_n = S_LEN_HI;
                else if (cmd_run)  state_n = S_RUN;
                else if (cmd_step) state_n = S_STEP;
            end
            S_RUN: begin
                if (det_hit)        state_n = S_DONE;
                else if (cmd_pause) state_n = S_PAUSE;
            end
            S_STEP:    state_n = det_hit ? S_DONE : S_PAUSE;
            S_DONE:    if (load_start) state_n = S_LEN_HI;
            default:   state_n = S_IDLE;
        endcase
    end

    // Every fresh program starts with a clean loop history.
    assign det_clear = (state_n == S_BOOT) && (state != S_BOOT);

    hack_loop_detect #(
        .ROM_AW   (ROM_AW),
        .HALT_CNT (HALT_CNT)
    ) u_loop_detect (
        .clk   (clk),
        .reset (reset),
        .clear (det_clear),
        .en    (cpu_en),
        .pc    (pc),
        .hit   (det_hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            len_hi    <= '0;
            hi_byte   <= '0;
            nwords    <= '0;
            widx      <= '0;
            boot_cnt  <= '0;
            rom_we    <= 1'b0;
            rom_addr  <= '0;
            rom_wdata <= '0;
        end else begin
            state  <= state_n;
            rom_we <= 1'b0;

            if ((state_n == S_LEN_HI) && (state != S_LEN_HI)) begin
                rom_addr <= '0;
                widx     <= '0;
            end

            if (hs) begin
                case (state)
                    S_LEN_HI:  len_hi  <= load_data;
                    S_LEN_LO:  nwords  <= {len_hi, load_data};
                    S_DATA_HI: hi_byte <= load_data;
                    S_DATA_LO: begin
                        rom_we <= in_range;
                        if (in_range) begin
                            rom_addr  <= widx[ROM_AW-1:0];
                            rom_wdata <= {hi_byte, load_data};
                        end
                        widx <= widx + 16'd1;
                    end
                    default: ;
                endcase
            end

            boot_cnt <= (state == S_BOOT) ? boot_cnt + BOOT_W'(1) : '0;
        end
    end

endmodule

// File: tb/tb_hack_boot_sequencer.sv
// Purpose: self-checking bench for hack_boot_sequencer (scoreboarded ROM writes, directed control checks).
// Latency: n/a.
// Backpressure: exercises stalled and continuous loader streams.
module tb_hack_boot_sequencer;

    localparam int ROM_AW      = 3;
    localparam int BOOT_CYCLES = 4;
    localparam int HALT_CNT    = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_start;
    logic              load_valid;
    logic [7:0]        load_data;
    logic              load_ready;
    logic              cmd_run;
    logic              cmd_step;
    logic              cmd_pause;
    logic [15:0]       pc;
    logic              rom_we;
    logic [ROM_AW-1:0] rom_addr;
    logic [15:0]       rom_wdata;
    logic              cpu_reset;
    logic              cpu_en;
    logic              halted;
    logic              busy_load;

    hack_boot_sequencer #(
        .ROM_AW      (ROM_AW),
        .BOOT_CYCLES (BOOT_CYCLES),
        .HALT_CNT    (HALT_CNT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .cmd_run    (cmd_run),
        .cmd_step   (cmd_step),
        .cmd_pause  (cmd_pause),
        .pc         (pc),
        .rom_we     (rom_we),
        .rom_addr   (rom_addr),
        .rom_wdata  (rom_wdata),
        .cpu_reset  (cpu_reset),
        .cpu_en     (cpu_en),
        .halted     (halted),
        .busy_load  (busy_load)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ROM_AW-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] load_words[$];
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every ROM write must match the next expected one.
    always @(negedge clk) begin : rom_monitor
        wr_t e;
        if (rom_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rom_write_unexpected: got addr %0d data 0x%04h, expected no write",
                         rom_addr, rom_wdata);
            end else begin
                e = exp_q.pop_front();
                check("rom_write_addr", 32'(rom_addr), 32'(e.addr));
                check("rom_write_data", 32'(rom_wdata), 32'(e.data));
                check("rom_write_cpu_reset", 32'(cpu_reset), 32'd1);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        if (gap) begin
            load_valid = 1'b0;
            @(negedge clk);
        end
        load_valid = 1'b1;
        load_data  = b;
        t = 0;
        while (!load_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("load_ready_wait", 32'(load_ready), 32'd1);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    // Pulses load_start (optionally with cmd_run), then streams load_words.
    task automatic do_load(input bit gaps, input bit also_run);
        int n;
        logic [15:0] w;
        n = load_words.size();
        load_start = 1'b1;
        cmd_run    = also_run;
        @(negedge clk);
        load_start = 1'b0;
        cmd_run    = 1'b0;
        check("load_start_accepted", 32'(busy_load), 32'd1);
        w = 16'(n);
        send_byte(w[15:8], gaps);
        send_byte(w[7:0], gaps);
        for (int i = 0; i < n; i++) begin
            w = load_words[i];
            if (i < (1 << ROM_AW))
                exp_q.push_back('{addr: ROM_AW'(i), data: w});
            send_byte(w[15:8], gaps);
            send_byte(w[7:0], gaps);
        end
    endtask

    // Called on the negedge right after the final load handshake.
    task automatic expect_boot();
        int n;
        n = 0;
        while (cpu_reset && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("boot_cycles", 32'(n), 32'(BOOT_CYCLES));
        check("pause_cpu_en", 32'(cpu_en), 32'd0);
        check("pause_load_ready", 32'(load_ready), 32'd0);
        check("pause_halted", 32'(halted), 32'd0);
    endtask

    function automatic logic [15:0] halt_pc(input int k);
        if (k < 5) return 16'(k);
        return (k % 2 == 1) ? 16'd3 : 16'd4;
    endfunction

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int cnt;
        int k;
        reset      = 1'b1;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        cmd_run    = 1'b0;
        cmd_step   = 1'b0;
        cmd_pause  = 1'b0;
        pc         = 16'd0;
        repeat (3) @(negedge clk);

        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_cpu_en", 32'(cpu_en), 32'd0);
        check("rst_rom_we", 32'(rom_we), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_rom_wdata", 32'(rom_wdata), 32'd0);
        check("rst_load_ready", 32'(load_ready), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_busy_load", 32'(busy_load), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Commands in IDLE have no effect.
        cmd_run = 1'b1;
        @(negedge clk);
        cmd_run = 1'b0;
        check("idle_cmd_ignored_rst", 32'(cpu_reset), 32'd1);
        check("idle_cmd_ignored_en", 32'(cpu_en), 32'd0);

        // Three words, valid held high.
        load_words = '{16'h3039, 16'hEC10, 16'h5BA0};
        do_load(1'b0, 1'b0);
        expect_boot();

        // Same program with a stalled stream.
        do_load(1'b1, 1'b0);
        expect_boot();
        check("gap_load_all_written", 32'(exp_q.size()), 32'd0);

        // Empty program: two bytes only, no ROM writes.
        load_words = {};
        do_load(1'b0, 1'b0);
        check("n0_no_more_bytes", 32'(load_ready), 32'd0);
        expect_boot();

        // Three single steps.
        for (int s = 0; s < 3; s++) begin
            cmd_step = 1'b1;
            @(negedge clk);
            cmd_step = 1'b0;
            cnt = 0;
            for (int c = 0; c < 4; c++) begin
                if (cpu_en) cnt++;
                @(negedge clk);
            end
            check("step_single_pulse", 32'(cnt), 32'd1);
        end

        // Free run, then pause.
        cmd_run = 1'b1;
        @(negedge clk);
        cmd_run = 1'b0;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (cpu_en) cnt++;
            @(negedge clk);
        end
        check("run_cpu_en_steady", 32'(cnt), 32'd10);
        cmd_pause = 1'b1;
        check("pause_cycle_still_en", 32'(cpu_en), 32'd1);
        @(negedge clk);
        cmd_pause = 1'b0;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (cpu_en) cnt++;
            @(negedge clk);
        end
        check("paused_cpu_en_low", 32'(cnt), 32'd0);

        // load_start outranks cmd_run in PAUSE; reload also clears the detector.
        do_load(1'b0, 1'b1);
        expect_boot();

        // Run (with step asserted too) into the END loop: 0,1,2,3,4,3,4,...
        cmd_run  = 1'b1;
        cmd_step = 1'b1;
        @(negedge clk);
        cmd_run  = 1'b0;
        cmd_step = 1'b0;
        check("run_beats_step", 32'(cpu_en), 32'd1);
        k   = 0;
        cnt = 0;
        while (!halted && cnt < 200) begin
            pc = halt_pc(k);
            if (cpu_en) k++;
            @(negedge clk);
            cnt++;
        end
        check("halt_after_enabled_cycles", 32'(k), 32'd20);
        check("done_halted", 32'(halted), 32'd1);
        check("done_cpu_en", 32'(cpu_en), 32'd0);
        check("done_cpu_reset", 32'(cpu_reset), 32'd0);
        cmd_run = 1'b1;
        @(negedge clk);
        cmd_run = 1'b0;
        @(negedge clk);
        check("done_ignores_run", 32'(halted), 32'd1);
        check("done_ignores_run_en", 32'(cpu_en), 32'd0);

        // Restart a load from DONE, then reset in the middle of DATA_LO.
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        check("done_load_start", 32'(busy_load), 32'd1);
        check("done_load_cpu_reset", 32'(cpu_reset), 32'd1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h11, 1'b0);
        load_valid = 1'b1;
        load_data  = 8'h22;
        reset      = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        load_valid = 1'b0;
        check("midload_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("midload_rst_load_ready", 32'(load_ready), 32'd0);
        check("midload_rst_rom_we", 32'(rom_we), 32'd0);
        check("midload_rst_busy", 32'(busy_load), 32'd0);
        @(negedge clk);

        // 2^ROM_AW + 1 words: eight writes, the ninth is dropped.
        load_words = {};
        for (int i = 0; i < (1 << ROM_AW) + 1; i++)
            load_words.push_back(16'hA000 + 16'(i * 16'h0101));
        do_load(1'b0, 1'b0);
        expect_boot();
        repeat (3) @(negedge clk);
        check("overflow_pending_writes", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
